// File: rtl/srflag_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : srflag_pkg (package)
//  Purpose  : Shared definitions for the set/reset flag bank arbiter:
//             op encodings and a constant clog2 helper for width math.
//  Revision : 1.0  initial release
// ============================================================================
package srflag_pkg;

  // Per-requester op encodings carried on req_op.
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_TAS = 2'b11;  // test-and-set or toggle, build dependent

  // Ceiling log2, clamped to a minimum of 1 so it is always a legal width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_n
//  Purpose  : Combinational round-robin arbiter. Grants the first valid
//             requester at or after ptr, wrapping N-1 -> 0. block forces
//             no grant. Reusable by any SELF sharing controller.
//  Ports    : valid     in  N    request vector
//             ptr       in  IDW  round-robin start position (< N)
//             block     in  1    suppress all grants this cycle
//             grant     out N    one-hot grant
//             grant_idx out IDW  index of granted requester (0 if none)
//             grant_any out 1    a grant was issued
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter_n #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  input  logic           block,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           grant_any
);

  always_comb begin
    int cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    if (!block) begin
      // Scan offsets 0..N-1 from ptr; first hit wins.
      for (int k = 0; k < N; k++) begin
        cand = int'(ptr) + k;
        if (cand >= N) begin
          cand = cand - N;
        end
        if (!grant_any && valid[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = IDW'(cand);
          grant_any   = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/srflag_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : srflag_bank_arbiter
//  Purpose  : Bank of M set/reset flags shared by N requesters over SELF
//             valid/stop channels. One op (SET/CLR/TOGGLE or TAS) accepted
//             per cycle under round-robin arbitration; clr_all wins over ops.
//  Config   : SRFLAG_TAS_EN defined   -> op 11 is test-and-set with a
//                                        one-cycle response strobe.
//             SRFLAG_TAS_EN undefined -> op 11 toggles; rsp_* tied to 0.
//  Ports    : clk, rst (sync, active high)
//             req_valid in N, req_stop out N, req_op in 2*N, req_idx in IDXW*N
//             clr_all in 1, q out M (registered)
//             rsp_valid/rsp_id/rsp_data out (TAS response)
//  Revision : 1.0  initial release
// ============================================================================
module srflag_bank_arbiter
  import srflag_pkg::*;
#(
  parameter int N    = 4,
  parameter int M    = 8,
  parameter int IDXW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_stop,
  input  logic [2*N-1:0]        req_op,
  input  logic [IDXW*N-1:0]     req_idx,
  input  logic                  clr_all,
  output logic [M-1:0]          q,
  output logic                  rsp_valid,
  output logic [clog2(N)-1:0]   rsp_id,
  output logic                  rsp_data
);

  localparam int IDW = clog2(N);

  logic [M-1:0]    r_q;
  logic [IDW-1:0]  r_ptr;
  logic [N-1:0]    w_grant;
  logic [IDW-1:0]  w_gidx;
  logic            w_xfer;
  logic            w_block;
  logic [1:0]      w_op;
  logic [IDXW-1:0] w_idx;
  logic [M-1:0]    w_mask;
  logic [M-1:0]    w_q_next;

  // Stop is forced during reset and clr_all so nothing is consumed then.
  assign w_block = rst | clr_all;

  rr_arbiter_n #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .valid     (req_valid),
    .ptr       (r_ptr),
    .block     (w_block),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .grant_any (w_xfer)
  );

  // Stop depends only on inputs and the pointer, never on q.
  always_comb begin
    req_stop = '1;
    if (!w_block) begin
      if (|req_valid) begin
        req_stop = ~w_grant;
      end else begin
        req_stop[r_ptr] = 1'b0;
      end
    end
  end

  // One-hot mux of the winner's op and index.
  always_comb begin
    w_op  = OP_NOP;
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_op  = w_op  | req_op[2*i +: 2];
        w_idx = w_idx | req_idx[IDXW*i +: IDXW];
      end
    end
  end

  // Out-of-range indices decode to an empty mask, so the op is a no-op.
  always_comb begin
    w_mask = '0;
    for (int j = 0; j < M; j++) begin
      if (w_idx == IDXW'(j)) begin
        w_mask[j] = 1'b1;
      end
    end
  end

  always_comb begin
    w_q_next = r_q;
    if (clr_all) begin
      w_q_next = '0;
    end else if (w_xfer) begin
      case (w_op)
        OP_SET:  w_q_next = r_q | w_mask;
        OP_CLR:  w_q_next = r_q & ~w_mask;
`ifdef SRFLAG_TAS_EN
        OP_TAS:  w_q_next = r_q | w_mask;
`else
        OP_TAS:  w_q_next = r_q ^ w_mask;
`endif
        default: w_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_ptr <= '0;
    end else begin
      r_q <= w_q_next;
      if (w_xfer) begin
        r_ptr <= (w_gidx == IDW'(N - 1)) ? '0 : w_gidx + IDW'(1);
      end
    end
  end

  assign q = r_q;

`ifdef SRFLAG_TAS_EN
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_rsp_data;
  logic            w_old;

  // Old value read through the same mask: zero for out-of-range indices.
  assign w_old = |(r_q & w_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= 1'b0;
    end else begin
      r_rsp_valid <= w_xfer && (w_op == OP_TAS);
      if (w_xfer && (w_op == OP_TAS)) begin
        r_rsp_id   <= w_gidx;
        r_rsp_data <= w_old;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
`else
  assign rsp_valid = 1'b0;
  assign rsp_id    = '0;
  assign rsp_data  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_srflag_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_srflag_bank_arbiter
//  Purpose  : Self-checking bench for srflag_bank_arbiter (N=4, M=6 so that
//             index 7 is out of range). Directed scenarios followed by
//             randomized traffic compared against a behavioural flag model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_srflag_bank_arbiter;

  localparam int N    = 4;
  localparam int M    = 6;
  localparam int IDXW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_stop;
  logic [2*N-1:0]    req_op;
  logic [IDXW*N-1:0] req_idx;
  logic              clr_all;
  logic [M-1:0]      q;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic              rsp_data;

  srflag_bank_arbiter #(
    .N    (N),
    .M    (M),
    .IDXW (IDXW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_stop  (req_stop),
    .req_op    (req_op),
    .req_idx   (req_idx),
    .clr_all   (clr_all),
    .q         (q),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit   mq [M];
  int   mptr;
  bit   mrv;
  int   mrid;
  bit   mrd;
  int   last_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [M-1:0] model_q();
    logic [M-1:0] v;
    for (int i = 0; i < M; i++) v[i] = mq[i];
    return v;
  endfunction

  // One clock: inputs already driven after a falling edge.
  task automatic cyc();
    int w;
    int c;
    int op;
    int idx;
    bit old;
    logic [N-1:0] es;
    #1;
    w = -1;
    if (!rst && !clr_all) begin
      for (int k = 0; k < N; k++) begin
        c = (mptr + k) % N;
        if (w < 0 && req_valid[c]) w = c;
      end
    end
    es = '1;
    if (!rst && !clr_all) begin
      if (w >= 0) es[w] = 1'b0;
      else        es[mptr] = 1'b0;
    end
    check("stop", req_stop, es);
    last_w = w;
    if (rst) begin
      for (int i = 0; i < M; i++) mq[i] = 1'b0;
      mptr = 0; mrv = 0; mrid = 0; mrd = 0;
    end else begin
      mrv = 0;
      if (clr_all) begin
        for (int i = 0; i < M; i++) mq[i] = 1'b0;
      end else if (w >= 0) begin
        op   = int'((req_op >> (2 * w)) & 8'd3);
        idx  = int'((req_idx >> (IDXW * w)) & 12'd7);
        mptr = (w + 1) % N;
        if (op == 3) begin
`ifdef SRFLAG_TAS_EN
          old = (idx < M) ? mq[idx] : 1'b0;
          if (idx < M) mq[idx] = 1'b1;
          mrv = 1; mrid = w; mrd = old;
`else
          old = 1'b0;
          if (idx < M) mq[idx] = ~mq[idx];
`endif
        end else if (idx < M) begin
          if (op == 1) mq[idx] = 1'b1;
          else if (op == 2) mq[idx] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    check("q", q, model_q());
    check("rsp_valid", rsp_valid, mrv);
`ifdef SRFLAG_TAS_EN
    if (mrv) begin
      check("rsp_id", rsp_id, mrid);
      check("rsp_data", rsp_data, mrd);
    end
`else
    check("rsp_id", rsp_id, 0);
    check("rsp_data", rsp_data, 0);
`endif
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = '1; req_op = '0; req_idx = '0; clr_all = 1'b0;
    mptr = 0; mrv = 0; mrid = 0; mrd = 0; last_w = -1;
    for (int i = 0; i < M; i++) mq[i] = 1'b0;
    @(negedge clk);

    // 1. Reset with all requesters valid
    cyc(); cyc();
    check("t1_stop", req_stop, 4'hF);
    check("t1_q", q, 0);
    check("t1_rsp", rsp_valid, 0);
    rst = 1'b0; req_valid = '0;
    #1 check("t1_ptr", req_stop, 4'b1110);
    cyc();

    // 2. Round-robin fairness
    req_valid = '1;
    req_op    = {2'b01, 2'b01, 2'b01, 2'b01};
    req_idx   = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < N; k++) begin
      cyc();
      check("t2_grant", last_w, k);
      req_valid[k] = 1'b0;
    end
    check("t2_q", q, 6'h0F);

    // 3. Conflict on one flag
    req_valid = 4'b0011;
    req_op    = {2'b00, 2'b00, 2'b10, 2'b01};
    req_idx   = {3'd0, 3'd0, 3'd5, 3'd5};
    cyc();
    check("t3_set", q[5], 1);
    req_valid[0] = 1'b0;
    cyc();
    check("t3_clr", q[5], 0);

    // 4. clr_all priority
    req_valid = 4'b0001;
    req_op    = {2'b00, 2'b00, 2'b00, 2'b01};
    for (int i = 0; i < M; i++) begin
      req_idx[2:0] = 3'(i);
      cyc();
    end
    check("t4_full", q, 6'h3F);
    req_valid = 4'b0100; req_op[5:4] = 2'b01; req_idx[8:6] = 3'd1; clr_all = 1'b1;
    #1 check("t4_stop", req_stop, 4'hF);
    cyc();
    check("t4_clr", q, 0);
    clr_all = 1'b0; req_valid = '0;
    #1 check("t4_ptr", req_stop, 4'b1101);
    req_valid = 4'b0100;
    cyc();
    check("t4_set", q, 6'h02);
    check("t4_grant", last_w, 2);

    // 5. Op 11 twice on idx3
    req_valid = 4'b1000; req_op[7:6] = 2'b11; req_idx[11:9] = 3'd3;
    cyc();
`ifdef SRFLAG_TAS_EN
    check("t5_rsp0", rsp_data, 0);
    check("t5_q0", q[3], 1);
`else
    check("t5_q0", q[3], 1);
    check("t5_rv0", rsp_valid, 0);
`endif
    cyc();
`ifdef SRFLAG_TAS_EN
    check("t5_rsp1", rsp_data, 1);
    check("t5_q1", q[3], 1);
`else
    check("t5_q1", q[3], 0);
    check("t5_rv1", rsp_valid, 0);
`endif

    // 6. Out-of-range index, then reset mid-stream
    req_valid = 4'b0010; req_op[3:2] = 2'b01; req_idx[5:3] = 3'd7;
    cyc();
    check("t6_grant", last_w, 1);
`ifdef SRFLAG_TAS_EN
    check("t6_q", q, 6'h0A);
`else
    check("t6_q", q, 6'h02);
`endif
    req_valid = 4'b1000; req_op[7:6] = 2'b11; req_idx[11:9] = 3'd1;
    cyc();
    rst = 1'b1; req_valid = '0;
    cyc();
    check("t6_rst_q", q, 0);
    check("t6_rst_rsp", rsp_valid, 0);
    rst = 1'b0;

    // Randomized traffic; pending ops stay stable until accepted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i]           = 1'b1;
          req_op[2*i +: 2]       = 2'($urandom);
          req_idx[IDXW*i +: IDXW] = 3'($urandom);
        end
      end
      rst     = ($urandom % 50 == 0);
      clr_all = ($urandom % 12 == 0);
      cyc();
      if (last_w >= 0) req_valid[last_w] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
